// File: rtl/mand_solver_scheduler_if.sv
// mand_solver_scheduler_if: valid/ready pixel-write port from the scheduler to the colour mapper
// master: drives pix_valid, pix_address, pix_iter; samples pix_ready
// slave:  samples pix_valid, pix_address, pix_iter; drives pix_ready
interface mand_solver_scheduler_if;
  logic pix_valid;
  logic pix_ready;
  logic [31:0] pix_address;
  logic [31:0] pix_iter;
  modport master (output pix_valid, pix_address, pix_iter, input pix_ready);
  modport slave (input pix_valid, pix_address, pix_iter, output pix_ready);
endinterface

// File: rtl/mand_solver_scheduler.sv
// mand_solver_scheduler: shares NUM_SOLVERS Mandelbrot solvers across one VGA frame, serialising results to a pixel port
// clock/reset: single clock, synchronous active-high reset
// start: begin a frame while idle; busy: frame in progress; frame_done: one-cycle pulse after the last pixel
// solver_reset/job_load/job_x/job_y: per-slot job dispatch; solver_out_ready/solver_out: per-slot results
// pix (master): pixel write request with address VGA_BASE_ADDRESS + y*X_MAX + x and raw iteration count
// MAND_SCHED_AUTO_RESTART_EN: when defined, a finished frame restarts at (0,0) without a new start
module mand_solver_scheduler #(
  parameter int NUM_SOLVERS = 4,
  parameter logic [31:0] VGA_BASE_ADDRESS = 32'h0000_0000,
  parameter int X_MAX = 640,
  parameter int Y_MAX = 480
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic [NUM_SOLVERS-1:0] solver_reset,
  output logic [NUM_SOLVERS-1:0] job_load,
  output logic [9:0] job_x,
  output logic [9:0] job_y,
  input  logic [NUM_SOLVERS-1:0] solver_out_ready,
  input  logic [32*NUM_SOLVERS-1:0] solver_out,
  mand_solver_scheduler_if.master pix,
  output logic frame_done,
  output logic busy
);
  localparam int PW = NUM_SOLVERS > 1 ? $clog2(NUM_SOLVERS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} slot_t;
  slot_t st [NUM_SOLVERS];
  slot_t st_nx [NUM_SOLVERS];
  logic [9:0] sx [NUM_SOLVERS];
  logic [9:0] sy [NUM_SOLVERS];
  logic [31:0] sres [NUM_SOLVERS];
  logic [9:0] rx, ry;
  logic pending;
  logic [PW-1:0] dptr, optr, osel;
  logic [NUM_SOLVERS-1:0] idle_m, done_m, left_m;
  logic [PW:0] dpick, opick;
  logic hs, disp, last_col, last_pix, frame_end;
  // first set bit of m at or after p, circularly; MSB flags that one was found
  function automatic logic [PW:0] pick(input logic [NUM_SOLVERS-1:0] m, input logic [PW-1:0] p);
    int j;
    pick = '0;
    for (int k = NUM_SOLVERS - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= NUM_SOLVERS) j -= NUM_SOLVERS;
      if (m[j]) pick = {1'b1, PW'(j)};
    end
  endfunction
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] s);
    nxt = int'(s) == NUM_SOLVERS - 1 ? '0 : s + 1'b1;
  endfunction
  always_comb begin
    hs = pix.pix_valid && pix.pix_ready;
    for (int i = 0; i < NUM_SOLVERS; i++) begin
      idle_m[i] = st[i] == IDLE;
      // the slot on the pixel port stays DONE until its handshake but must not be picked again
      done_m[i] = st[i] == DONE && !(pix.pix_valid && PW'(i) == osel);
      left_m[i] = st[i] != IDLE && !(hs && PW'(i) == osel);
      solver_reset[i] = st[i] != RUN;
    end
    dpick = pick(idle_m, dptr);
    opick = pick(done_m, optr);
    disp = busy && pending && dpick[PW];
    last_col = int'(rx) == X_MAX - 1;
    last_pix = last_col && int'(ry) == Y_MAX - 1;
    frame_end = busy && !pending && hs && left_m == '0;
    for (int i = 0; i < NUM_SOLVERS; i++) begin
      st_nx[i] = st[i];
      if (st[i] == RUN && solver_out_ready[i]) st_nx[i] = DONE;
      if (hs && PW'(i) == osel) st_nx[i] = IDLE;
      if (disp && PW'(i) == dpick[PW-1:0]) st_nx[i] = RUN;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      st <= '{default: IDLE};
      busy <= 1'b0;
      pending <= 1'b0;
      rx <= '0;
      ry <= '0;
      dptr <= '0;
      optr <= '0;
      osel <= '0;
      job_load <= '0;
      job_x <= '0;
      job_y <= '0;
      pix.pix_valid <= 1'b0;
      pix.pix_address <= '0;
      pix.pix_iter <= '0;
      frame_done <= 1'b0;
    end else begin
      st <= st_nx;
      frame_done <= frame_end;
      job_load <= '0;
      if (!busy && start) begin
        busy <= 1'b1;
        pending <= 1'b1;
        rx <= '0;
        ry <= '0;
      end
      if (disp) begin
        job_load[dpick[PW-1:0]] <= 1'b1;
        job_x <= rx;
        job_y <= ry;
        sx[dpick[PW-1:0]] <= rx;
        sy[dpick[PW-1:0]] <= ry;
        dptr <= nxt(dpick[PW-1:0]);
        rx <= last_col ? '0 : rx + 10'd1;
        ry <= last_col ? ry + 10'd1 : ry;
        if (last_pix) pending <= 1'b0;
      end
      for (int i = 0; i < NUM_SOLVERS; i++)
        if (st[i] == RUN && solver_out_ready[i]) sres[i] <= solver_out[32*i +: 32];
      if (hs) pix.pix_valid <= 1'b0;
      if ((!pix.pix_valid || hs) && opick[PW]) begin
        pix.pix_valid <= 1'b1;
        pix.pix_address <= VGA_BASE_ADDRESS + 32'(sy[opick[PW-1:0]]) * 32'(X_MAX) + 32'(sx[opick[PW-1:0]]);
        pix.pix_iter <= sres[opick[PW-1:0]];
        osel <= opick[PW-1:0];
        optr <= nxt(opick[PW-1:0]);
      end
      if (frame_end) begin
`ifdef MAND_SCHED_AUTO_RESTART_EN
        pending <= 1'b1;
        rx <= '0;
        ry <= '0;
`else
        busy <= 1'b0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_mand_solver_scheduler.sv
// tb_mand_solver_scheduler: randomized solver latencies/backpressure checked against a per-pixel frame model
module tb_mand_solver_scheduler;
  localparam int N = 2;
  localparam int XM = 4;
  localparam int YM = 2;
  localparam int NP = XM * YM;
  localparam logic [31:0] BASE = 32'h100;
`ifdef MAND_SCHED_AUTO_RESTART_EN
  localparam logic AUTO = 1'b1;
`else
  localparam logic AUTO = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic pix_ready = 1'b0;
  logic [N-1:0] solver_reset, job_load;
  logic [N-1:0] solver_out_ready = '0;
  logic [9:0] job_x, job_y;
  logic [32*N-1:0] solver_out = '0;
  logic frame_done, busy;
  mand_solver_scheduler_if pix ();
  assign pix.pix_ready = pix_ready;
  mand_solver_scheduler #(.NUM_SOLVERS(N), .VGA_BASE_ADDRESS(BASE), .X_MAX(XM), .Y_MAX(YM)) dut (
    .clock(clock), .reset(reset), .start(start), .solver_reset(solver_reset), .job_load(job_load),
    .job_x(job_x), .job_y(job_y), .solver_out_ready(solver_out_ready), .solver_out(solver_out),
    .pix(pix), .frame_done(frame_done), .busy(busy));
  always #5 clock = ~clock;
  int compared = 0, mismatched = 0;
  int cnt [N];
  int sol_pix [N];
  logic [31:0] sol_val [N];
  logic running [N], occupied [N], clr [N];
  logic [31:0] exp_iter [NP];
  logic exp_ok [NP], seen [NP];
  int slot_of [NP];
  int n_disp = 0, n_pix = 0, n_done = 0, cyc = 0, fixed_lat = 3, pr_mode = 0;
  logic [31:0] seed = 0;
  int lat_q [$];
  logic [31:0] val_q [$];
  logic [31:0] hs_a [$];
  logic [31:0] hs_i [$];
  int hs_c [$];
  logic prev_hold = 1'b0;
  logic [31:0] prev_a, prev_i;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clear_frame();
    n_disp = 0;
    n_pix = 0;
    for (int i = 0; i < NP; i++) begin
      seen[i] = 1'b0;
      exp_ok[i] = 1'b0;
    end
  endtask
  task automatic tick();
    int s, lat;
    logic [31:0] off;
    if (prev_hold) begin
      chk("hold_valid", 32'(pix.pix_valid), 1);
      chk("hold_addr", pix.pix_address, prev_a);
      chk("hold_iter", pix.pix_iter, prev_i);
    end
    if (pix.pix_valid && pix_ready) begin
      off = pix.pix_address - BASE;
      chk("pix_in_frame", 32'(off < NP), 1);
      if (off < NP) begin
        chk("pix_once", 32'(seen[off]), 0);
        chk("pix_known", 32'(exp_ok[off]), 1);
        chk("pix_iter", pix.pix_iter, exp_iter[off]);
        seen[off] = 1'b1;
        occupied[slot_of[off]] = 1'b0;
      end
      n_pix++;
      hs_a.push_back(pix.pix_address);
      hs_i.push_back(pix.pix_iter);
      hs_c.push_back(cyc);
    end
    if (job_load != '0) begin
      chk("load_onehot", $countones(job_load), 1);
      chk("load_count", 32'(n_disp < NP), 1);
      chk("load_x", 32'(job_x), 32'(n_disp % XM));
      chk("load_y", 32'(job_y), 32'(n_disp / XM));
      s = 0;
      for (int i = 0; i < N; i++) if (job_load[i]) s = i;
      chk("load_free", 32'(occupied[s]), 0);
      lat = lat_q.size() > 0 ? lat_q.pop_front() : fixed_lat > 0 ? fixed_lat : int'($urandom_range(1, 6));
      sol_val[s] = val_q.size() > 0 ? val_q.pop_front() : seed + 32'(job_x) + 32'd10 * 32'(job_y);
      cnt[s] = lat;
      running[s] = 1'b1;
      occupied[s] = 1'b1;
      if (n_disp < NP) begin
        sol_pix[s] = n_disp;
        slot_of[n_disp] = s;
      end
      n_disp++;
    end
    for (int i = 0; i < N; i++) begin
      chk("solver_reset", 32'(solver_reset[i]), 32'(!running[i]));
      if (clr[i]) begin
        running[i] = 1'b0;
        clr[i] = 1'b0;
      end
    end
    if (frame_done) begin
      chk("done_pixels", n_pix, NP);
      chk("done_busy", 32'(busy), 32'(AUTO));
      chk("done_all_idle", 32'(solver_reset), {N{1'b1}});
      n_done++;
      clear_frame();
    end
    prev_hold = pix.pix_valid && !pix_ready;
    prev_a = pix.pix_address;
    prev_i = pix.pix_iter;
    @(posedge clock);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      solver_out_ready[i] = 1'b0;
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          solver_out_ready[i] = 1'b1;
          solver_out[32*i +: 32] = sol_val[i];
          exp_iter[sol_pix[i]] = sol_val[i];
          exp_ok[sol_pix[i]] = 1'b1;
          clr[i] = 1'b1;
        end
      end
    end
    if (pr_mode == 1) pix_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic apply_reset();
    reset = 1'b1;
    solver_out_ready = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      running[i] = 1'b0;
      occupied[i] = 1'b0;
      clr[i] = 1'b0;
    end
    clear_frame();
    prev_hold = 1'b0;
    chk("rst_pix_valid", 32'(pix.pix_valid), 0);
    chk("rst_solver_reset", 32'(solver_reset), {N{1'b1}});
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_job_load", 32'(job_load), 0);
    chk("rst_job_xy", {12'd0, job_y, job_x}, 0);
    chk("rst_pix_address", pix.pix_address, 0);
    chk("rst_pix_iter", pix.pix_iter, 0);
  endtask
  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
  endtask
  task automatic run_frame(input int budget);
    int d0;
    d0 = n_done;
    for (int k = 0; k < budget && n_done == d0; k++) tick();
    chk("frame_completes", n_done, d0 + 1);
  endtask
  initial begin
    apply_reset();
`ifdef MAND_SCHED_AUTO_RESTART_EN
    pr_mode = 1;
    fixed_lat = 0;
    seed = 32'h5000;
    start_frame();
    for (int k = 0; k < 400 && n_done < 3; k++) begin
      tick();
      chk("auto_busy", 32'(busy), 1);
    end
    chk("auto_frames", n_done, 3);
    apply_reset();
`else
    pr_mode = 0;
    pix_ready = 1'b1;
    fixed_lat = 3;
    seed = 0;
    start_frame();
    chk("start_no_load", 32'(job_load), 0);
    tick();
    chk("first_load", 32'(job_load), 1);
    run_frame(100);
    tick();
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_frames", n_done, 1);
    // backpressure
    start_frame();
    pr_mode = 2;
    pix_ready = 1'b0;
    for (int k = 0; k < 40 && !pix.pix_valid; k++) tick();
    chk("bp_valid_seen", 32'(pix.pix_valid), 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_no_load", 32'(job_load), 0);
    end
    pix_ready = 1'b1;
    pr_mode = 0;
    run_frame(100);
    // simultaneous completion
    apply_reset();
    hs_a.delete();
    hs_i.delete();
    hs_c.delete();
    lat_q = '{4, 3};
    val_q = '{32'd7, 32'hffff_ffff};
    start_frame();
    run_frame(100);
    chk("sim_first_addr", hs_a[0], BASE);
    chk("sim_first_iter", hs_i[0], 7);
    chk("sim_second_addr", hs_a[1], BASE + 1);
    chk("sim_second_iter", hs_i[1], 32'hffff_ffff);
    chk("sim_back_to_back", hs_c[1], hs_c[0] + 1);
    // reset mid-frame
    pr_mode = 1;
    fixed_lat = 0;
    seed = 32'h3000;
    start_frame();
    for (int k = 0; k < 200 && n_pix < 3; k++) tick();
    chk("mid_three_pixels", n_pix, 3);
    apply_reset();
    start_frame();
    run_frame(300);
    // ignored start
    start_frame();
    for (int k = 0; k < 4; k++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_frame(300);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("idle_no_load", 32'(job_load), 0);
      chk("idle_no_done", 32'(frame_done), 0);
      chk("idle_busy", 32'(busy), 0);
    end
    // ready on idle slots is ignored
    solver_out_ready = '1;
    solver_out = {N{32'hdead_beef}};
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("idle_ready_ignored", 32'(pix.pix_valid), 0);
    end
    // randomized frames
    for (int f = 0; f < 4; f++) begin
      seed = $urandom;
      start_frame();
      run_frame(300);
    end
    chk("total_frames", n_done, 9);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mand_solver_scheduler.md
# mand_solver_scheduler

Frame scheduler that shares a pool of `NUM_SOLVERS` Mandelbrot solver instances across the pixels of one frame. It walks the VGA raster and dispatches pixel jobs to idle solvers, round-robin. It collects finished iteration counts and serialises them onto a single valid/ready pixel-write port that feeds the colour mapper and VGA memory writer. The block performs no coordinate scaling and no colouring. Those stay in the per-slot datapath and downstream logic.

## Interface
- `NUM_SOLVERS`, 4: number of solver slots, 1..8.
- `VGA_BASE_ADDRESS`, 32'h0000_0000: address of pixel (0,0).
- `X_MAX`, 640: pixels per line.
- `Y_MAX`, 480: lines per frame.

Ports:
- `clock`  in  1  single clock. All logic is on posedge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin a frame. Sampled only while `busy`=0.
- `solver_reset`  out  NUM_SOLVERS  per-slot solver reset. High while the slot is not running.
- `job_load`  out  NUM_SOLVERS  one-hot, one-cycle strobe. The strobed slot captures `job_x`/`job_y`.
- `job_x`  out  10  pixel x of the dispatched job.
- `job_y`  out  10  pixel y of the dispatched job.
- `solver_out_ready`  in  NUM_SOLVERS  per-slot result valid.
- `solver_out`  in  32*NUM_SOLVERS  per-slot iteration count. Slot i occupies bits [32i+31:32i].
- `pix_valid`  out  1  pixel write request.
- `pix_ready`  in  1  downstream accepts the pixel.
- `pix_address`  out  32  write address.
- `pix_iter`  out  32  raw iteration count. -1 means in-set.
- `frame_done`  out  1  one-cycle pulse after the last pixel handshake of a frame.
- `busy`  out  1  frame in progress.

## Operation
- Per-slot state is one of IDLE, RUN, DONE. Each slot holds a registered x, y and result.
- **Frame start:** `start`=1 while `busy`=0 sets `busy`, sets the raster to (0,0) and arms dispatch. `start` is ignored while `busy`=1.
- **Dispatch:**
  - At most one job per cycle, only while raster pixels remain.
  - Target is the first IDLE slot at or after the round-robin dispatch pointer. The pointer then advances to slot+1, mod NUM_SOLVERS.
  - On dispatch: `job_load[i]`=1 for one cycle, with `job_x`/`job_y` equal to the current raster position. The slot goes to RUN. `solver_reset[i]` falls on the next edge.
- **Raster order:** x runs 0..X_MAX-1, then x returns to 0 and y increments. After (X_MAX-1, Y_MAX-1) is dispatched, no further jobs are issued that frame.
- **Completion:** `solver_out_ready[i]` is sampled only in RUN. When sampled high, the slot captures `solver_out[i]`, goes to DONE, and `solver_reset[i]` rises. Ready seen in IDLE or DONE is ignored.
- **Output arbiter:**
  - Round-robin over DONE slots with an independent pointer.
  - The winner drives `pix_iter` and `pix_address` = VGA_BASE_ADDRESS + y*X_MAX + x, computed modulo 2^32.
  - `pix_valid`=1 until `pix_valid`&&`pix_ready`. Address and data stay stable while `pix_valid`=1 and `pix_ready`=0.
  - On handshake the slot goes to IDLE. It is eligible for dispatch from the next cycle, not the same cycle.
- **Frame end:** when all pixels are dispatched, every slot is IDLE and the final handshake has occurred, `frame_done` pulses for one cycle and `busy` falls on the same edge.
- Pixels may be written out of raster order. Each pixel is written exactly once per frame.

## Timing
- **Reset values:**
  - `solver_reset` all 1.
  - `job_load`, `job_x`, `job_y`, `pix_valid`, `pix_address`, `pix_iter`, `frame_done`, `busy` all 0.
  - Both round-robin pointers 0.
- **`start` to first job:** `start` sampled at edge T; `busy`=1 after T; first `job_load` after T+1.
- **Result to pixel:** `solver_out_ready` sampled at edge E; slot is DONE after E; `pix_valid` is asserted after E+1 at the earliest (registered arbiter).
- **Throughput:** one dispatch and one pixel handshake per cycle, both in the same cycle.
- **Simultaneous events:**
  - A slot finishing while another is being dispatched: both proceed.
  - Two slots finishing in the same cycle: both go to DONE and are drained in round-robin order.
- **Reset mid-frame:** all outputs return to reset values within the same edge. All slots go to IDLE and in-flight results are discarded. `frame_done` does not pulse.
- **Degenerate case:** with NUM_SOLVERS=1 the block still operates, fully serialised.

## Configuration
- `MAND_SCHED_AUTO_RESTART_EN`
  - **Defined:** on the edge where `frame_done` pulses, `busy` stays 1, the raster restarts at (0,0), and dispatch resumes on the next cycle without `start`. `start` is then unused after the first frame.
  - **Undefined:** `busy` falls with `frame_done`, and each frame needs a fresh `start`.

## Test plan
Bench parameters are X_MAX=4, Y_MAX=2, NUM_SOLVERS=2, base 32'h100, unless noted.

1. **Single frame, no backpressure.** Single `start`; each solver returns ready 3 cycles after load with `solver_out` = x+10y; `pix_ready`=1 -> 8 handshakes, addresses 0x100..0x107 each exactly once, `pix_iter` matches x+10y per address, one `frame_done`, `busy`=0 afterwards.
2. **Backpressure.** `pix_ready` held 0 for 5 cycles while `pix_valid`=1 -> `pix_address`/`pix_iter` unchanged. `job_load` stops once both slots are DONE and resumes after the handshake.
3. **Simultaneous completion.** Both slots assert ready in the same cycle with `solver_out` 7 and -1 -> two consecutive pixels in round-robin order; the -1 passes through unaltered.
4. **Reset mid-frame.** Assert `reset` after 3 handshakes -> next cycle `pix_valid`=0, `solver_reset`=2'b11, `busy`=0, no `frame_done`. A new `start` restarts at (0,0).
5. **Ignored start.** Pulse `start` during a busy frame -> no effect; exactly 8 pixels and one `frame_done`.
6. **Auto-restart.** With `MAND_SCHED_AUTO_RESTART_EN`, a single `start` -> `frame_done` pulses every frame, `busy` never falls, and the second frame's first `job_load` carries x=0, y=0.
